// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Operands are accepted through a
//   valid/ready handshake. One difference bit is produced per clock,
//   LSB first, by a single full-subtractor cell. The result is then
//   offered through a second valid/ready handshake.
//
// Parameters
//   WIDTH      operand/result width in bits (1..32)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand transfer request
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result available (DONE)
//   out_ready  downstream accepts the result
//   diff       difference, (a - b - bin) mod 2^WIDTH
//   bout       final borrow-out
//   busy       operation in progress or result pending (RUN or DONE)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  // Counter must be able to hold WIDTH itself, so it never wraps.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-bit full subtractor: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic br);
    logic d;
    logic br_next;
    d       = x ^ y ^ br;
    br_next = (~x & y) | (~(x ^ y) & br);
    return {br_next, d};
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic             br_r, br_nxt_s;
  logic [WIDTH-1:0] diff_r, diff_nxt_s;
  logic             bout_r, bout_nxt_s;
  logic [1:0]       cell_s;
  logic [WIDTH-1:0] msb_bit_s;

  // Handshake outputs are pure decodes of the state register (and reset).
  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign diff      = diff_r;
  assign bout      = bout_r;

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    br_nxt_s    = br_r;
    diff_nxt_s  = diff_r;
    bout_nxt_s  = bout_r;
    // The operand copies shift right, so bit 'counter' always sits at index 0.
    cell_s      = fs_cell(a_r[0], b_r[0], br_r);
    msb_bit_s   = '0;
    msb_bit_s[WIDTH-1] = cell_s[0];

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_nxt_s     = a;
          b_nxt_s     = b;
          br_nxt_s    = bin;
          cnt_nxt_s   = '0;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // New bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
        diff_nxt_s = (diff_r >> 1) | msb_bit_s;
        a_nxt_s    = a_r >> 1;
        b_nxt_s    = b_r >> 1;
        br_nxt_s   = cell_s[1];
        cnt_nxt_s  = cnt_r + CW'(1);
        if (cnt_r == LAST) begin
          bout_nxt_s  = cell_s[1];
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: counter, operand shifters, borrow and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      br_r   <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      a_r    <= a_nxt_s;
      b_r    <= b_nxt_s;
      br_r   <= br_nxt_s;
      diff_r <= diff_nxt_s;
      bout_r <= bout_nxt_s;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: three instances (WIDTH 8, 4, 1) share
// operand/reset/out_ready stimulus, each with its own in_valid.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_ready;

  wire  [2:0] ir;
  wire  [2:0] ov;
  wire  [2:0] bo;
  wire  [2:0] bsy;
  wire  [7:0] df8;
  wire  [3:0] df4;
  wire        df1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .bin(bin), .out_valid(ov[0]), .out_ready(out_ready),
    .diff(df8), .bout(bo[0]), .busy(bsy[0])
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a[3:0]), .b(b[3:0]), .bin(bin), .out_valid(ov[1]), .out_ready(out_ready),
    .diff(df4), .bout(bo[1]), .busy(bsy[1])
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a[0:0]), .b(b[0:0]), .bin(bin), .out_valid(ov[2]), .out_ready(out_ready),
    .diff(df1), .bout(bo[2]), .busy(bsy[2])
  );

  function automatic int width_of(input int k);
    case (k)
      0: return 8;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] dfx(input int k);
    case (k)
      0: return df8;
      1: return {4'b0000, df4};
      default: return {7'b0000000, df1};
    endcase
  endfunction

  // Reference: plain integer arithmetic, returns {bout, diff[7:0]}.
  function automatic logic [8:0] model(input int w, input int av, input int bv, input int bi);
    int m;
    int x;
    int y;
    logic [8:0] r;
    m = (1 << w) - 1;
    x = av & m;
    y = bv & m;
    r[7:0] = 8'((x - y - bi) & m);
    r[8]   = (x < (y + bi));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation on instance k. hold = cycles of out_ready=0 in DONE;
  // jam = wiggle in_valid/operands every cycle during RUN.
  task automatic do_op(input int k, input int av, input int bv, input int bi,
                       input int hold, input bit jam);
    int w;
    int n;
    logic [8:0] e;
    logic [7:0] d0;
    logic       b0;
    w = width_of(k);
    e = model(w, av, bv, bi);
    chk("pre_in_ready", 32'(ir[k]), 32'd1);
    a = av[7:0];
    b = bv[7:0];
    bin = bi[0];
    out_ready = (hold == 0);
    iv[k] = 1'b1;
    @(posedge clk); #1;
    if (!jam) iv[k] = 1'b0;
    chk("run_busy", 32'(bsy[k]), 32'd1);
    n = 0;
    while (ov[k] !== 1'b1 && n < 64) begin
      if (jam) begin
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
        iv[k] = ~iv[k];
      end
      chk("run_in_ready", 32'(ir[k]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(w));
    chk("diff", 32'(dfx(k)), 32'(e[7:0]));
    chk("bout", 32'(bo[k]), 32'(e[8]));
    d0 = dfx(k);
    b0 = bo[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(ov[k]), 32'd1);
      chk("hold_diff", 32'(dfx(k)), 32'(d0));
      chk("hold_bout", 32'(bo[k]), 32'(b0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", 32'(ov[k]), 32'd0);
    chk("post_busy", 32'(bsy[k]), 32'd0);
    chk("post_in_ready", 32'(ir[k]), 32'd1);
    chk("retain_diff", 32'(dfx(k)), 32'(e[7:0]));
    iv[k] = 1'b0;
  endtask

  initial begin
    int n;
    iv = 3'b000;
    a = 8'h00;
    b = 8'h00;
    bin = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir[0]), 32'd0);
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_diff", 32'(df8), 32'd0);
    chk("rst_bout", 32'(bo[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(ir[0]), 32'd1);

    // Directed cases
    do_op(0, 32'h5A, 32'h3C, 0, 0, 1'b0);
    do_op(0, 32'h00, 32'h01, 0, 0, 1'b0);
    do_op(0, 32'hFF, 32'hFF, 1, 0, 1'b0);
    do_op(0, 32'h80, 32'h00, 1, 0, 1'b0);
    chk("dir_80_00", 32'(df8), 32'h7F);
    // Backpressure
    do_op(0, 32'hC3, 32'h5D, 1, 5, 1'b0);
    // Input noise during RUN
    do_op(0, 32'h21, 32'h9E, 0, 0, 1'b1);

    // Reset while processing bit 3
    a = 8'hA7; b = 8'h3B; bin = 1'b1; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_run_in_ready", 32'(ir[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(ov[0]), 32'd0);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_diff", 32'(df8), 32'd0);
    chk("abort_bout", 32'(bo[0]), 32'd0);
    chk("abort_in_ready", 32'(ir[0]), 32'd1);
    n = 0;
    repeat (12) begin @(posedge clk); #1; n += int'(ov[0]); end
    chk("abort_no_valid", 32'(n), 32'd0);
    do_op(0, 32'h10, 32'h01, 0, 0, 1'b0);

    // Random WIDTH=8 operations
    for (int i = 0; i < 20; i++)
      do_op(0, int'($urandom_range(255)), int'($urandom_range(255)),
            int'($urandom_range(1)), int'($urandom_range(2)), 1'($urandom_range(1)));

    // Exhaustive WIDTH=4, back-to-back
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          do_op(1, x, y, c, 0, 1'b0);

    // Exhaustive WIDTH=1
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++)
          do_op(2, x, y, c, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
